// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep controller: steps a tuning word once per dwell and turns the phase
// accumulator into quarter-wave sine ROM addressing.
module dds_sweep_ctrl #(
    parameter int unsigned PHASE_W    = 16,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DWELL_W    = 16,
    parameter int unsigned SAMPLE_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_start_inc,
    input  logic [PHASE_W-1:0] cfg_stop_inc,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_repeat,
    input  logic               start,
    input  logic               abort,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_negate,
    output logic               sample_valid,
    output logic [PHASE_W-1:0] cur_inc,
    output logic               busy,
    output logic               done
);
    localparam int unsigned PresW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PresW-1:0] PresLast = PresW'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic               configured_q, configured_d;
    logic [PHASE_W-1:0] start_inc_q, start_inc_d;
    logic [PHASE_W-1:0] stop_inc_q, stop_inc_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               repeat_q, repeat_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] cur_inc_q, cur_inc_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [PresW-1:0]   presc_q, presc_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               rom_negate_q, rom_negate_d;
    logic               sample_valid_q, sample_valid_d;

    logic [PHASE_W-1:0] phase_sum;
    logic [1:0]         quad;
    logic [ADDR_W-1:0]  idx;
    logic [PHASE_W:0]   next_inc;
    logic [DWELL_W-1:0] dwell_eff;
    logic               cfg_fire;

    assign phase_sum = phase_q + cur_inc_q;
    assign quad      = phase_sum[PHASE_W-1 -: 2];
    assign idx       = phase_sum[PHASE_W-3 -: ADDR_W];
    // One extra bit so a step past the top of the range cannot wrap under the limit.
    assign next_inc  = {1'b0, cur_inc_q} + {1'b0, step_q};
    assign dwell_eff = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
    assign cfg_fire  = cfg_valid && (state_q == StIdle);

    always_comb begin
        state_d        = state_q;
        configured_d   = configured_q;
        start_inc_d    = start_inc_q;
        stop_inc_d     = stop_inc_q;
        step_d         = step_q;
        dwell_d        = dwell_q;
        repeat_d       = repeat_q;
        phase_d        = phase_q;
        cur_inc_d      = cur_inc_q;
        dwell_cnt_d    = dwell_cnt_q;
        presc_d        = presc_q;
        rom_addr_d     = rom_addr_q;
        rom_negate_d   = rom_negate_q;
        sample_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_fire) begin
                    start_inc_d  = cfg_start_inc;
                    stop_inc_d   = cfg_stop_inc;
                    step_d       = cfg_step;
                    dwell_d      = cfg_dwell;
                    repeat_d     = cfg_repeat;
                    configured_d = 1'b1;
                end
                if (start && (configured_q || cfg_fire)) begin
                    state_d     = StRun;
                    phase_d     = '0;
                    cur_inc_d   = cfg_fire ? cfg_start_inc : start_inc_q;
                    dwell_cnt_d = '0;
                    presc_d     = '0;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    if (presc_q == PresLast) begin
                        presc_d        = '0;
                        phase_d        = phase_sum;
                        rom_addr_d     = quad[0] ? ~idx : idx;
                        rom_negate_d   = quad[1];
                        sample_valid_d = 1'b1;
                        dwell_cnt_d    = dwell_cnt_q + DWELL_W'(1);
                    end else begin
                        presc_d = presc_q + PresW'(1);
                    end
                    // Dwell is settled in the strobe cycle so cur_inc still names the
                    // word that produced the strobed sample.
                    if (sample_valid_q && (dwell_cnt_q == dwell_eff)) begin
                        dwell_cnt_d = '0;
                        if (next_inc <= {1'b0, stop_inc_q}) begin
                            cur_inc_d = next_inc[PHASE_W-1:0];
                        end else if (repeat_q) begin
                            cur_inc_d = start_inc_q;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            configured_q   <= 1'b0;
            start_inc_q    <= '0;
            stop_inc_q     <= '0;
            step_q         <= '0;
            dwell_q        <= '0;
            repeat_q       <= 1'b0;
            phase_q        <= '0;
            cur_inc_q      <= '0;
            dwell_cnt_q    <= '0;
            presc_q        <= '0;
            rom_addr_q     <= '0;
            rom_negate_q   <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            configured_q   <= configured_d;
            start_inc_q    <= start_inc_d;
            stop_inc_q     <= stop_inc_d;
            step_q         <= step_d;
            dwell_q        <= dwell_d;
            repeat_q       <= repeat_d;
            phase_q        <= phase_d;
            cur_inc_q      <= cur_inc_d;
            dwell_cnt_q    <= dwell_cnt_d;
            presc_q        <= presc_d;
            rom_addr_q     <= rom_addr_d;
            rom_negate_q   <= rom_negate_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign cfg_ready    = (state_q == StIdle);
    assign busy         = (state_q == StRun);
    assign done         = (state_q == StDone);
    assign rom_addr     = rom_addr_q;
    assign rom_negate   = rom_negate_q;
    assign sample_valid = sample_valid_q;
    assign cur_inc      = cur_inc_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed and random sweeps checked against an arithmetic model
// of the expected strobe sequence.
module tb_dds_sweep_ctrl;
    localparam int SDIV = 4;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_start_inc;
    logic [15:0] cfg_stop_inc;
    logic [15:0] cfg_step;
    logic [15:0] cfg_dwell;
    logic        cfg_repeat;
    logic        start;
    logic        abort;
    logic [6:0]  rom_addr;
    logic        rom_negate;
    logic        sample_valid;
    logic [15:0] cur_inc;
    logic        busy;
    logic        done;

    dds_sweep_ctrl #(
        .PHASE_W    (16),
        .ADDR_W     (7),
        .DWELL_W    (16),
        .SAMPLE_DIV (SDIV)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_start_inc (cfg_start_inc),
        .cfg_stop_inc  (cfg_stop_inc),
        .cfg_step      (cfg_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_repeat    (cfg_repeat),
        .start         (start),
        .abort         (abort),
        .rom_addr      (rom_addr),
        .rom_negate    (rom_negate),
        .sample_valid  (sample_valid),
        .cur_inc       (cur_inc),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Configuration the model believes is latched in the DUT.
    logic [15:0] m_start, m_stop, m_step, m_dwell;
    logic        m_rep;

    logic [15:0] e_inc  [$];
    logic [6:0]  e_addr [$];
    logic        e_neg  [$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected strobes from the sweep rules: phase accumulates, word advances per dwell.
    task automatic build_model(input int nmax, output int nexp, output bit fin);
        int unsigned ph, inc, cnt, dw, quad, idx;
        ph  = 0;
        inc = m_start;
        cnt = 0;
        dw  = (m_dwell == 0) ? 1 : m_dwell;
        fin = 1'b0;
        e_inc.delete();
        e_addr.delete();
        e_neg.delete();
        while (e_inc.size() < nmax && !fin) begin
            ph   = (ph + inc) % 65536;
            quad = ph / 16384;
            idx  = (ph / 128) % 128;
            e_inc.push_back(16'(inc));
            e_addr.push_back(7'((quad % 2 == 1) ? 127 - idx : idx));
            e_neg.push_back(quad >= 2);
            cnt++;
            if (cnt == dw) begin
                cnt = 0;
                if (inc + m_step <= m_stop) inc = inc + m_step;
                else if (m_rep) inc = m_start;
                else fin = 1'b1;
            end
        end
        nexp = e_inc.size();
    endtask

    task automatic launch(input bit with_cfg, input bit same_cycle);
        if (with_cfg) begin
            cfg_start_inc = m_start;
            cfg_stop_inc  = m_stop;
            cfg_step      = m_step;
            cfg_dwell     = m_dwell;
            cfg_repeat    = m_rep;
            cfg_valid     = 1'b1;
            if (!same_cycle) begin
                @(negedge clk);
                cfg_valid = 1'b0;
            end
        end
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic check_strobe(input int k, input int cyc);
        if (k >= e_inc.size()) begin
            chk_eq("extra_strobe", k + 1, e_inc.size());
        end else begin
            chk_eq("strobe_time", cyc, (k + 1) * SDIV);
            chk_eq("cur_inc", cur_inc, e_inc[k]);
            chk_eq("rom_addr", rom_addr, e_addr[k]);
            chk_eq("rom_negate", rom_negate, e_neg[k]);
        end
    endtask

    // Follows one sweep from RUN entry; open-ended sweeps are aborted after nmax strobes.
    task automatic run_check(input int nmax, input bit inject);
        int nexp, k, cyc, last, w, quiet, budget;
        bit fin, seen;
        build_model(nmax, nexp, fin);
        chk_eq("run_entry_busy", busy, 1);
        k      = 0;
        cyc    = 0;
        last   = 0;
        seen   = 1'b0;
        budget = (nexp + 2) * SDIV + 8;
        if (fin) begin
            while (!seen && cyc < budget) begin
                @(negedge clk);
                cyc++;
                if (sample_valid) begin
                    check_strobe(k, cyc);
                    k++;
                    last = cyc;
                end
                if (done) begin
                    chk_eq("done_time", cyc, last + 1);
                    chk_eq("done_count", k, nexp);
                    chk_eq("done_busy", busy, 0);
                    seen = 1'b1;
                end
            end
            if (!seen) chk_eq("done_seen", 0, 1);
            @(negedge clk);
            chk_eq("idle_ready", cfg_ready, 1);
            chk_eq("idle_done_low", done, 0);
            chk_eq("rom_hold", rom_addr, e_addr[nexp-1]);
        end else begin
            while (k < nexp && cyc < budget) begin
                @(negedge clk);
                cyc++;
                if (inject && cyc == 1) begin
                    cfg_start_inc = 16'($urandom);
                    cfg_stop_inc  = 16'($urandom);
                    cfg_step      = 16'($urandom);
                    cfg_dwell     = 16'($urandom_range(0, 5));
                    cfg_repeat    = 1'($urandom);
                    cfg_valid     = 1'b1;
                    chk_eq("cfg_ready_run", cfg_ready, 0);
                end
                if (cyc == 2) cfg_valid = 1'b0;
                if (sample_valid) begin
                    check_strobe(k, cyc);
                    k++;
                end
                if (done) chk_eq("no_done_run", done, 0);
            end
            if (k < nexp) chk_eq("strobes_seen", k, nexp);
            w = $urandom_range(0, SDIV - 1);
            repeat (w) begin
                @(negedge clk);
                chk_eq("pre_abort_gap", {sample_valid, done}, 0);
            end
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk_eq("abort_busy", busy, 0);
            chk_eq("abort_valid", sample_valid, 0);
            chk_eq("abort_done", done, 0);
            quiet = 0;
            repeat (2 * SDIV) begin
                @(negedge clk);
                quiet += int'(sample_valid) + int'(done) + int'(busy);
            end
            chk_eq("abort_quiet", quiet, 0);
        end
    endtask

    task automatic expect_no_run(input string tag);
        int act;
        launch(1'b0, 1'b0);
        act = 0;
        repeat (2 * SDIV) begin
            @(negedge clk);
            act += int'(busy) + int'(sample_valid);
        end
        chk_eq(tag, act, 0);
    endtask

    task automatic set_cfg(input logic [15:0] s, input logic [15:0] p, input logic [15:0] st,
                           input logic [15:0] d, input logic r);
        m_start = s;
        m_stop  = p;
        m_step  = st;
        m_dwell = d;
        m_rep   = r;
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_start_inc = '0;
        cfg_stop_inc = '0;
        cfg_step = '0;
        cfg_dwell = '0;
        cfg_repeat = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("rst_rom_addr", rom_addr, 0);
        chk_eq("rst_rom_neg", rom_negate, 0);
        chk_eq("rst_valid", sample_valid, 0);
        chk_eq("rst_cur_inc", cur_inc, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_ready", cfg_ready, 1);

        expect_no_run("unconfigured_start");

        // Single sweep, two samples per word, ends with done.
        set_cfg(16'h0400, 16'h0C00, 16'h0400, 16'd2, 1'b0);
        launch(1'b1, 1'b1);
        run_check(40, 1'b0);

        // Quarter-wave mapping with a fixed word; limit equal to start.
        set_cfg(16'h4000, 16'h4000, 16'h0000, 16'd1, 1'b0);
        launch(1'b1, 1'b0);
        run_check(8, 1'b0);

        // Repeat mode wraps back to the start word.
        set_cfg(16'h1000, 16'h2000, 16'h1000, 16'd1, 1'b1);
        launch(1'b1, 1'b1);
        run_check(6, 1'b0);

        // Start above stop: one dwell then done.
        set_cfg(16'h3000, 16'h1000, 16'h0100, 16'd0, 1'b0);
        launch(1'b1, 1'b1);
        run_check(40, 1'b0);

        // Abort after third strobe with a config offer during RUN, then rerun old config.
        set_cfg(16'h0200, 16'hF000, 16'h0100, 16'd1, 1'b0);
        launch(1'b1, 1'b0);
        run_check(3, 1'b1);
        launch(1'b0, 1'b0);
        run_check(5, 1'b0);

        // Reset in the middle of a sweep.
        launch(1'b0, 1'b0);
        repeat (SDIV * 2 + 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_eq("midrst_busy", busy, 0);
        chk_eq("midrst_valid", sample_valid, 0);
        chk_eq("midrst_cur_inc", cur_inc, 0);
        chk_eq("midrst_rom_addr", rom_addr, 0);
        chk_eq("midrst_rom_neg", rom_negate, 0);
        chk_eq("midrst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("midrst_ready", cfg_ready, 1);
        expect_no_run("start_after_reset");

        for (int i = 0; i < 24; i++) begin
            set_cfg(16'($urandom), 16'($urandom), 16'($urandom_range(0, 16'h3000)),
                    16'($urandom_range(0, 3)), 1'($urandom));
            launch(1'b1, 1'($urandom));
            run_check(20, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                launch(1'b0, 1'b0);
                run_check(12, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
